// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX holding register feeding the ALU, with MEM/WB bypass,
// load-use stall and WB snooping so held operands never go stale.
module alu_issue_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [RADDR-1:0] in_rs1_addr,
  input  logic [RADDR-1:0] in_rs2_addr,
  input  logic [RADDR-1:0] in_rd_addr,
  input  logic [XLEN-1:0]  in_imm,
  input  logic             in_use_imm,
  input  logic [3:0]       in_aluctr,
  input  logic             in_reg_write,
  input  logic [RADDR-1:0] mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_is_load,
  input  logic [XLEN-1:0]  mem_result,
  input  logic [RADDR-1:0] wb_rd,
  input  logic             wb_reg_write,
  input  logic [XLEN-1:0]  wb_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [3:0]       alu_aluctr,
  output logic [RADDR-1:0] out_rd_addr,
  output logic             out_reg_write
);
  logic             v, use_imm, reg_write, hazard, fire, cap;
  logic [RADDR-1:0] rs1, rs2, rd;
  logic [XLEN-1:0]  d1, d2, imm;
  logic [3:0]       aluctr;
  function automatic logic [XLEN-1:0] byp(input logic [RADDR-1:0] s, input logic [XLEN-1:0] d);
    return s == '0 ? '0 :
           (mem_reg_write && mem_rd == s && !mem_is_load) ? mem_result :
           (wb_reg_write && wb_rd == s) ? wb_result : d;
  endfunction
  // register-file write in the same cycle is not yet visible in the read data
  function automatic logic [XLEN-1:0] wbfix(input logic [RADDR-1:0] s, input logic [XLEN-1:0] d);
    return (wb_reg_write && wb_rd == s && s != '0) ? wb_result : d;
  endfunction
  assign hazard        = v && mem_is_load && mem_reg_write && mem_rd != '0 &&
                         (mem_rd == rs1 || (!use_imm && mem_rd == rs2));
  assign out_valid     = v && !hazard;
  assign fire          = out_valid && out_ready;
  assign in_ready      = !v || fire;
  assign cap           = in_valid && in_ready && !flush;
  assign alu_a         = byp(rs1, d1);
  assign alu_b         = use_imm ? imm : byp(rs2, d2);
  assign alu_aluctr    = aluctr;
  assign out_rd_addr   = rd;
  assign out_reg_write = reg_write && out_valid;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v         <= 1'b0;
      rs1       <= '0;
      rs2       <= '0;
      rd        <= '0;
      d1        <= '0;
      d2        <= '0;
      imm       <= '0;
      use_imm   <= 1'b0;
      aluctr    <= '0;
      reg_write <= 1'b0;
    end else begin
      v <= flush ? 1'b0 : cap ? 1'b1 : fire ? 1'b0 : v;
      if (cap) begin
        rs1       <= in_rs1_addr;
        rs2       <= in_rs2_addr;
        rd        <= in_rd_addr;
        d1        <= wbfix(in_rs1_addr, in_rs1_data);
        d2        <= wbfix(in_rs2_addr, in_rs2_data);
        imm       <= in_imm;
        use_imm   <= in_use_imm;
        aluctr    <= in_aluctr;
        reg_write <= in_reg_write;
      end else if (v && !fire) begin
        d1 <= wbfix(rs1, d1);
        d2 <= wbfix(rs2, d2);
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: architectural register-file model plus one-deep
// instruction queue scoreboard, directed scenarios then random traffic.
module tb_alu_issue_stage;
  logic        clk = 0, rst_n = 0, flush, in_valid, in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, mem_result, wb_result, alu_a, alu_b;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, mem_rd, wb_rd, out_rd_addr;
  logic        in_use_imm, in_reg_write, mem_reg_write, mem_is_load, wb_reg_write;
  logic        out_valid, out_ready, out_reg_write;
  logic [3:0]  in_aluctr, alu_aluctr;

  alu_issue_stage #(.XLEN(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rs1_addr(in_rs1_addr),
    .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_aluctr(in_aluctr), .in_reg_write(in_reg_write),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_is_load(mem_is_load),
    .mem_result(mem_result), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .wb_result(wb_result), .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_aluctr(alu_aluctr),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ui;
    logic [3:0]  ctl;
    logic        rw;
  } ins_t;

  ins_t        q[$];
  logic [31:0] rf[32];
  int          checks = 0, failures = 0, nfire = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // architectural value of a source as the ALU must see it this cycle
  function automatic logic [31:0] opnd(input logic [4:0] s);
    if (s == 0) return 0;
    if (mem_reg_write && mem_rd == s && !mem_is_load) return mem_result;
    if (wb_reg_write && wb_rd == s) return wb_result;
    return rf[s];
  endfunction

  always @(negedge clk) begin
    if (!rst_n) q.delete();
    else begin
      automatic logic held = q.size() > 0;
      automatic ins_t h = held ? q[0] : '0;
      automatic logic haz = held && mem_is_load && mem_reg_write && mem_rd != 0 &&
                            (mem_rd == h.rs1 || (!h.ui && mem_rd == h.rs2));
      automatic logic eov = held && !haz;
      automatic logic eir = !held || (eov && out_ready);
      chk("out_valid", 32'(out_valid), 32'(eov));
      chk("in_ready", 32'(in_ready), 32'(eir));
      chk("out_reg_write", 32'(out_reg_write), 32'(eov && h.rw));
      if (eov) begin
        chk("alu_a", alu_a, opnd(h.rs1));
        chk("alu_b", alu_b, h.ui ? h.imm : opnd(h.rs2));
        chk("alu_aluctr", 32'(alu_aluctr), 32'(h.ctl));
        chk("out_rd_addr", 32'(out_rd_addr), 32'(h.rd));
      end
      if (eov && out_ready) nfire++;
      if (held && ((eov && out_ready) || flush)) void'(q.pop_front());
      if (in_valid && eir && !flush)
        q.push_back('{in_rs1_addr, in_rs2_addr, in_rd_addr, in_imm, in_use_imm, in_aluctr, in_reg_write});
      if (wb_reg_write && wb_rd != 0) rf[wb_rd] = wb_result;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1;
    mem_reg_write = 0; mem_is_load = 0; mem_rd = 0; mem_result = 0;
    wb_reg_write = 0; wb_rd = 0; wb_result = 0;
  endtask

  task automatic offer(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rd,
                       input logic [31:0] imm, input logic ui, input logic [3:0] ctl, input logic rw);
    in_valid = 1; in_rs1_addr = r1; in_rs2_addr = r2; in_rd_addr = rd;
    in_rs1_data = r1 == 0 ? $urandom : rf[r1];
    in_rs2_data = r2 == 0 ? $urandom : rf[r2];
    in_imm = imm; in_use_imm = ui; in_aluctr = ctl; in_reg_write = rw;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 0;
    idle();
    offer(0, 0, 0, 0, 0, 0, 0);
    in_valid = 0;
    repeat (3) step();
    rst_n = 1;
    #1;
    chk("rst in_ready", 32'(in_ready), 1);
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst out_reg_write", 32'(out_reg_write), 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    chk("rst alu_aluctr", 32'(alu_aluctr), 0);
    chk("rst out_rd_addr", 32'(out_rd_addr), 0);
    for (int r = 1; r < 32; r++) begin
      idle(); wb_reg_write = 1; wb_rd = 5'(r); wb_result = $urandom;
      step();
    end
    // back-to-back ADDs
    idle(); offer(1, 2, 3, 0, 0, 4'd2, 1); step();
    idle(); offer(4, 5, 6, 0, 0, 4'd2, 1); #1; chk("b2b v1", 32'(out_valid), 1); step();
    idle(); offer(8, 9, 10, 0, 0, 4'd2, 1); #1; chk("b2b v2", 32'(out_valid), 1); step();
    idle(); #1; chk("b2b v3", 32'(out_valid), 1); chk("b2b ctl", 32'(alu_aluctr), 2); step();
    // MEM beats WB; x0 reads as zero
    idle(); offer(5, 6, 1, 0, 0, 4'd2, 1); step();
    idle(); mem_reg_write = 1; mem_rd = 5; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 5; wb_result = 32'h22; #1;
    chk("mem over wb", alu_a, 32'h11); step();
    idle(); offer(0, 6, 1, 0, 0, 4'd2, 1); step();
    idle(); mem_reg_write = 1; mem_rd = 0; mem_result = 32'h11;
    wb_reg_write = 1; wb_rd = 0; wb_result = 32'h22; #1;
    chk("x0 operand", alu_a, 0); step();
    // load-use stall then WB delivers the load
    idle(); offer(1, 7, 2, 0, 0, 4'd2, 1); step();
    idle(); offer(9, 9, 9, 0, 0, 4'd1, 1);
    mem_reg_write = 1; mem_is_load = 1; mem_rd = 7; #1;
    chk("load-use out_valid", 32'(out_valid), 0);
    chk("load-use in_ready", 32'(in_ready), 0); step();
    idle(); wb_reg_write = 1; wb_rd = 7; wb_result = 32'hABCD; #1;
    chk("load-use alu_b", alu_b, 32'hABCD);
    chk("load-use resume", 32'(out_valid), 1); step();
    idle(); offer(1, 7, 2, 32'h1234, 1, 4'd2, 1); step();
    idle(); mem_reg_write = 1; mem_is_load = 1; mem_rd = 7; #1;
    chk("imm no stall", 32'(out_valid), 1);
    chk("imm alu_b", alu_b, 32'h1234); step();
    // WB snoop during downstream stall
    idle(); offer(3, 4, 5, 0, 0, 4'd6, 1); step();
    idle(); out_ready = 0; wb_reg_write = 1; wb_rd = 3; wb_result = 32'h55; step();
    idle(); out_ready = 0; step();
    idle(); out_ready = 0; step();
    idle(); #1; chk("snoop alu_a", alu_a, 32'h55); chk("snoop valid", 32'(out_valid), 1); step();
    // flush while holding, and flush with an empty stage
    idle(); offer(1, 2, 3, 0, 0, 4'd7, 1); step();
    idle(); out_ready = 0; flush = 1; offer(4, 5, 6, 0, 0, 4'd12, 1); step();
    idle(); #1; chk("flush out_valid", 32'(out_valid), 0); chk("flush out_rw", 32'(out_reg_write), 0); step();
    idle(); flush = 1; offer(4, 5, 6, 0, 0, 4'd12, 1); #1; chk("flush in_ready", 32'(in_ready), 1); step();
    idle(); #1; chk("flush no capture", 32'(out_valid), 0); step();
    // asynchronous reset mid-hold
    idle(); offer(1, 2, 3, 0, 0, 4'd2, 1); step();
    idle(); out_ready = 0; #1; chk("pre-reset valid", 32'(out_valid), 1);
    rst_n = 0; #1;
    chk("async reset valid", 32'(out_valid), 0);
    chk("async reset in_ready", 32'(in_ready), 1);
    step(); rst_n = 1; idle(); step();
    chk("post-reset alu_a", alu_a, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      offer(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom, 1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)));
      in_valid = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 19) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      mem_reg_write = 1'($urandom_range(0, 1)); mem_is_load = $urandom_range(0, 2) == 0;
      mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
      step();
    end
    idle(); repeat (3) step();
    chk("random fires", 32'(nfire > 500), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
